ajuste_hhmm: RTL and testbench

Button-driven time-setting controller for the HH:MM clock. It produces the `newHoras`/`newMinutos` values and the active-low `establecer` strobe that the clock counter consumes. The user edits hours, then minutes, with debounced push-buttons, and commits the result. The `establecer` strobe is held low until a 1 Hz tick has been seen, so the counter is guaranteed to load the values. It sits between the board keys/switches and the clock counter, and feeds the display while editing.

---
 rtl/reloj_pkg.sv | 28 ++
 rtl/ajuste_hhmm_if.sv | 20 ++
 rtl/ajuste_hhmm_antirrebote.sv | 47 ++++
 rtl/ajuste_hhmm.sv | 134 +++++++++++++
 tb/tb_ajuste_hhmm.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/reloj_pkg.sv
// Shared types and limits for the HH:MM clock and its time-setting controller.
// The state encoding doubles as the editando output code.
package reloj_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    EDIT_HH = 2'b01,
    EDIT_MM = 2'b10,
    COMMIT  = 2'b11
  } estado_ajuste_t;

  localparam logic [4:0] MAX_HORAS   = 5'd23;
  localparam logic [5:0] MAX_MINUTOS = 6'd59;

  // One inc/dec step with wrap at both ends; both requests together cancel out.
  function automatic logic [5:0] paso_campo(input logic [5:0] valor,
                                            input logic [5:0] maximo,
                                            input logic       sube,
                                            input logic       baja);
    paso_campo = valor;
    if (sube && !baja) begin
      paso_campo = (valor == maximo) ? 6'd0 : valor + 6'd1;
    end else if (baja && !sube) begin
      paso_campo = (valor == 6'd0) ? maximo : valor - 6'd1;
    end
  endfunction

endpackage

// File: rtl/ajuste_hhmm_if.sv
// Link between the time-setting controller (master) and the clock counter (slave).
// establecer is active-low; the counter loads newHoras/newMinutos on clk1hz while it is low.
interface ajuste_hhmm_if;
  logic       clk1hz;
  logic [4:0] horasActual;
  logic [5:0] minutosActual;
  logic [4:0] newHoras;
  logic [5:0] newMinutos;
  logic       establecer;

  modport master (
    input  clk1hz, horasActual, minutosActual,
    output newHoras, newMinutos, establecer
  );

  modport slave (
    output clk1hz, horasActual, minutosActual,
    input  newHoras, newMinutos, establecer
  );
endinterface

// File: rtl/ajuste_hhmm_antirrebote.sv
// Key conditioner: 2-flop sync, stability counter, registered press pulse (active-low key).
// Press pulse appears DEBOUNCE_CYCLES+2 cycles after a clean fall; nivel_o is the debounced held level.
module antirrebote #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic tecla_i,
  output logic pulso_o,
  output logic nivel_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic             sinc1_q, sinc2_q, estable_q, pulso_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sinc1_q   <= 1'b1;
      sinc2_q   <= 1'b1;
      estable_q <= 1'b1;
      pulso_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sinc1_q <= tecla_i;
      sinc2_q <= sinc1_q;
      pulso_q <= 1'b0;
      // Accept the new level only after it has differed for DEBOUNCE_CYCLES samples in a row.
      if (sinc2_q != estable_q) begin
        if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          estable_q <= sinc2_q;
          pulso_q   <= ~sinc2_q;
          cnt_q     <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign pulso_o = pulso_q;
  assign nivel_o = ~estable_q;

endmodule

// File: rtl/ajuste_hhmm.sv
// Button-driven HH:MM setting FSM; key to output latency DEBOUNCE_CYCLES+3, establecer held low until a 1 Hz tick is seen.
// Optional auto-repeat of held inc/dec keys is built only when AUTOREPEAT_EN is defined.
module ajuste_hhmm
  import reloj_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          switch1,
  input  logic          btnSel,
  input  logic          btnInc,
  input  logic          btnDec,
  input  logic          btnSet,
  ajuste_hhmm_if.master bus,
  output logic [1:0]    editando
);

  // Key index: 0 sel, 1 inc, 2 dec, 3 set.
  logic [3:0] teclas, pulso, nivel;
  logic [1:0] paso;
  logic       unused_ok;

  assign teclas = {btnSet, btnDec, btnInc, btnSel};

  for (genvar i = 0; i < 4; i++) begin : g_tecla
    antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_antirrebote (
      .clk     (clk),
      .reset   (reset),
      .tecla_i (teclas[i]),
      .pulso_o (pulso[i]),
      .nivel_o (nivel[i])
    );
  end

`ifdef AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  for (genvar k = 0; k < 2; k++) begin : g_repite
    logic [REP_W-1:0] rep_cnt_q;
    logic             rep_fase_q;
    logic             disparo;

    // First repeat waits REPEAT_DELAY after the press step, later ones REPEAT_PERIOD.
    assign disparo = nivel[k+1] && !pulso[k+1] &&
                     (rep_cnt_q == (rep_fase_q ? REP_W'(REPEAT_PERIOD - 1)
                                               : REP_W'(REPEAT_DELAY - 1)));

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rep_cnt_q  <= '0;
        rep_fase_q <= 1'b0;
      end else if (pulso[k+1] || !nivel[k+1]) begin
        rep_cnt_q  <= '0;
        rep_fase_q <= 1'b0;
      end else if (disparo) begin
        rep_cnt_q  <= '0;
        rep_fase_q <= 1'b1;
      end else begin
        rep_cnt_q <= rep_cnt_q + 1'b1;
      end
    end

    assign paso[k] = pulso[k+1] | disparo;
  end

  assign unused_ok = ^{nivel[0], nivel[3]};
`else
  assign paso      = pulso[2:1];
  assign unused_ok = ^{nivel, REPEAT_DELAY, REPEAT_PERIOD};
`endif

  estado_ajuste_t estado_q;
  logic [4:0]     horas_q;
  logic [5:0]     minutos_q;
  logic           establecer_q, tick_q;
  logic [5:0]     horas_ext_d, minutos_d;
  logic           unused_bits;

  assign horas_ext_d = paso_campo({1'b0, horas_q}, {1'b0, MAX_HORAS}, paso[0], paso[1]);
  assign minutos_d   = paso_campo(minutos_q, MAX_MINUTOS, paso[0], paso[1]);
  assign unused_bits = horas_ext_d[5];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q     <= IDLE;
      horas_q      <= 5'd0;
      minutos_q    <= 6'd0;
      establecer_q <= 1'b1;
      tick_q       <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      case (estado_q)
        IDLE: begin
          horas_q   <= bus.horasActual;
          minutos_q <= bus.minutosActual;
          if (switch1 && pulso[0]) estado_q <= EDIT_HH;
        end
        EDIT_HH, EDIT_MM: begin
          if (!switch1) begin
            estado_q <= IDLE;
          end else if (pulso[3]) begin
            estado_q     <= COMMIT;
            establecer_q <= 1'b0;
          end else if (pulso[0]) begin
            estado_q <= (estado_q == EDIT_HH) ? EDIT_MM : EDIT_HH;
          end else if (estado_q == EDIT_HH) begin
            horas_q <= horas_ext_d[4:0];
          end else begin
            minutos_q <= minutos_d;
          end
        end
        COMMIT: begin
          // Leave one cycle after the tick, so the counter samples establecer=0 on the tick itself.
          if (!switch1 || tick_q) begin
            estado_q     <= IDLE;
            establecer_q <= 1'b1;
          end else begin
            tick_q <= bus.clk1hz;
          end
        end
      endcase
    end
  end

  assign bus.newHoras   = horas_q;
  assign bus.newMinutos = minutos_q;
  assign bus.establecer = establecer_q;
  assign editando       = estado_q;

endmodule

// File: tb/tb_ajuste_hhmm.sv
// Directed bench for ajuste_hhmm with DEBOUNCE_CYCLES=4; expectations queued per cycle, checked by a negedge monitor.
module tb_ajuste_hhmm;

  localparam int K_SEL = 0, K_INC = 1, K_DEC = 2, K_SET = 3;

  typedef struct {
    int         at;
    string      name;
    logic [4:0] h;
    logic [5:0] m;
    logic       est;
    logic [1:0] ed;
  } exp_t;

  logic clk = 1'b0;
  logic reset, switch1, btnSel, btnInc, btnDec, btnSet;
  logic [1:0] editando;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  ajuste_hhmm_if bus ();

  ajuste_hhmm #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (20),
    .REPEAT_PERIOD   (5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .switch1  (switch1),
    .btnSel   (btnSel),
    .btnInc   (btnInc),
    .btnDec   (btnDec),
    .btnSet   (btnSet),
    .bus      (bus.master),
    .editando (editando)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].at <= cyc) begin
      mon_e = sb_q.pop_front();
      n_cmp++;
      if (bus.newHoras !== mon_e.h || bus.newMinutos !== mon_e.m ||
          bus.establecer !== mon_e.est || editando !== mon_e.ed) begin
        n_err++;
        $display("FAIL %s (cyc %0d): got %0d:%0d est=%b ed=%b, want %0d:%0d est=%b ed=%b",
                 mon_e.name, cyc, bus.newHoras, bus.newMinutos, bus.establecer, editando,
                 mon_e.h, mon_e.m, mon_e.est, mon_e.ed);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int dly, input string nm, input logic [4:0] h,
                           input logic [5:0] m, input logic est, input logic [1:0] ed);
    exp_t e;
    e.at = cyc + dly; e.name = nm; e.h = h; e.m = m; e.est = est; e.ed = ed;
    sb_q.push_back(e);
  endtask

  task automatic set_key(input int k, input logic v);
    case (k)
      K_SEL:   btnSel = v;
      K_INC:   btnInc = v;
      K_DEC:   btnDec = v;
      default: btnSet = v;
    endcase
  endtask

  // Hold a key low for 'hold' cycles, then leave it released long enough to debounce.
  task automatic press_key(input int k, input int hold);
    set_key(k, 1'b0);
    tick(hold);
    set_key(k, 1'b1);
    tick(12);
  endtask

  initial begin
    reset = 1'b0; switch1 = 1'b0;
    btnSel = 1'b1; btnInc = 1'b1; btnDec = 1'b1; btnSet = 1'b1;
    bus.clk1hz = 1'b0; bus.horasActual = 5'd7; bus.minutosActual = 6'd15;

    tick(2);
    expect_at(0, "reset_vals", 5'd0, 6'd0, 1'b1, 2'd0);
    reset = 1'b1;
    expect_at(1, "track_after_reset", 5'd7, 6'd15, 1'b1, 2'd0);
    tick(3);

    bus.horasActual = 5'd23; bus.minutosActual = 6'd0; switch1 = 1'b1;
    expect_at(6, "before_sel", 5'd23, 6'd0, 1'b1, 2'd0);
    expect_at(7, "enter_hh", 5'd23, 6'd0, 1'b1, 2'd1);
    press_key(K_SEL, 10);

    bus.horasActual = 5'd5; bus.minutosActual = 6'd40;
    expect_at(6, "before_inc", 5'd23, 6'd0, 1'b1, 2'd1);
    expect_at(7, "inc_wrap_hh", 5'd0, 6'd0, 1'b1, 2'd1);
    press_key(K_INC, 10);

    expect_at(7, "enter_mm", 5'd0, 6'd0, 1'b1, 2'd2);
    press_key(K_SEL, 10);
    expect_at(7, "dec_wrap_mm", 5'd0, 6'd59, 1'b1, 2'd2);
    press_key(K_DEC, 10);
    expect_at(8, "glitch_early", 5'd0, 6'd59, 1'b1, 2'd2);
    expect_at(14, "glitch_late", 5'd0, 6'd59, 1'b1, 2'd2);
    press_key(K_INC, 3);

    switch1 = 1'b0; bus.horasActual = 5'd12; bus.minutosActual = 6'd34;
    expect_at(1, "abort_edit", 5'd0, 6'd59, 1'b1, 2'd0);
    expect_at(2, "track_12_34", 5'd12, 6'd34, 1'b1, 2'd0);
    tick(4);

    switch1 = 1'b1;
    expect_at(7, "enter_hh_12", 5'd12, 6'd34, 1'b1, 2'd1);
    press_key(K_SEL, 10);
    expect_at(7, "enter_mm_34", 5'd12, 6'd34, 1'b1, 2'd2);
    press_key(K_SEL, 10);

    bus.horasActual = 5'd1; bus.minutosActual = 6'd2;
    btnInc = 1'b0; btnDec = 1'b0;
    expect_at(7, "inc_dec_same", 5'd12, 6'd34, 1'b1, 2'd2);
    expect_at(12, "inc_dec_hold", 5'd12, 6'd34, 1'b1, 2'd2);
    tick(10);
    btnInc = 1'b1; btnDec = 1'b1;
    tick(12);

    // clk1hz high on the accepting edge must not end the commit
    btnSet = 1'b0;
    expect_at(6, "before_set", 5'd12, 6'd34, 1'b1, 2'd2);
    expect_at(7, "commit_entry", 5'd12, 6'd34, 1'b0, 2'd3);
    expect_at(9, "tick_on_accept_ignored", 5'd12, 6'd34, 1'b0, 2'd3);
    tick(6);
    bus.clk1hz = 1'b1;
    tick(1);
    bus.clk1hz = 1'b0;
    tick(3);
    btnSet = 1'b1;
    tick(20);

    bus.clk1hz = 1'b1;
    expect_at(1, "tick_cycle_loads", 5'd12, 6'd34, 1'b0, 2'd3);
    expect_at(2, "commit_exit", 5'd12, 6'd34, 1'b1, 2'd0);
    expect_at(3, "track_after_commit", 5'd1, 6'd2, 1'b1, 2'd0);
    tick(1);
    bus.clk1hz = 1'b0;
    tick(4);

    expect_at(7, "enter_hh_1", 5'd1, 6'd2, 1'b1, 2'd1);
    press_key(K_SEL, 10);
    expect_at(7, "commit_2", 5'd1, 6'd2, 1'b0, 2'd3);
    press_key(K_SET, 10);
    switch1 = 1'b0; bus.horasActual = 5'd9; bus.minutosActual = 6'd45;
    expect_at(0, "still_commit", 5'd1, 6'd2, 1'b0, 2'd3);
    expect_at(1, "abort_commit", 5'd1, 6'd2, 1'b1, 2'd0);
    expect_at(2, "track_9_45", 5'd9, 6'd45, 1'b1, 2'd0);
    tick(4);

`ifdef AUTOREPEAT_EN
    switch1 = 1'b1;
    expect_at(7, "ar_enter", 5'd9, 6'd45, 1'b1, 2'd1);
    press_key(K_SEL, 10);
    btnInc = 1'b0;
    expect_at(7, "ar_first", 5'd10, 6'd45, 1'b1, 2'd1);
    expect_at(26, "ar_before_second", 5'd10, 6'd45, 1'b1, 2'd1);
    expect_at(27, "ar_second", 5'd11, 6'd45, 1'b1, 2'd1);
    expect_at(31, "ar_before_third", 5'd11, 6'd45, 1'b1, 2'd1);
    expect_at(32, "ar_third", 5'd12, 6'd45, 1'b1, 2'd1);
    expect_at(47, "ar_sixth", 5'd15, 6'd45, 1'b1, 2'd1);
    expect_at(60, "ar_released", 5'd15, 6'd45, 1'b1, 2'd1);
    tick(44);
    btnInc = 1'b1;
    tick(20);
`endif

    switch1 = 1'b0;
    tick(4);
    switch1 = 1'b1;
    expect_at(7, "enter_hh_9", 5'd9, 6'd45, 1'b1, 2'd1);
    press_key(K_SEL, 10);
    expect_at(7, "commit_3", 5'd9, 6'd45, 1'b0, 2'd3);
    press_key(K_SET, 10);
    reset = 1'b0;
    expect_at(0, "reset_in_commit", 5'd0, 6'd0, 1'b1, 2'd0);
    expect_at(2, "reset_held", 5'd0, 6'd0, 1'b1, 2'd0);
    tick(3);
    reset = 1'b1;
    expect_at(1, "track_after_reset2", 5'd9, 6'd45, 1'b1, 2'd0);
    tick(4);

    if (sb_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
